// File: rtl/calc_pkg.sv
// calc_pkg: status codes, command codes, state encoding and limits for calc_param
package calc_pkg;
  localparam logic [1:0] ST_ERR = 2'b00, ST_BUSY = 2'b01, ST_READY = 2'b10;
  localparam logic [3:0] CMD_ADD = 4'hA, CMD_SUB = 4'hB, CMD_MUL = 4'hC, CMD_DIV = 4'hD, CMD_EQ = 4'hE, CMD_BKSP = 4'hF;
  typedef enum logic [2:0] {S_A, S_B, S_MUL, S_DIV, S_ERR} calc_state_t;
  function automatic longint unsigned max_val(input int ndig);
    longint unsigned m = 1;
    for (int i = 0; i < ndig; i++) m = m * 10;
    return m - 1;
  endfunction
endpackage

// File: rtl/calc_muldiv.sv
// calc_muldiv: shared sequential shift-add multiplier / restoring divider, W iterations per op
module calc_muldiv #(
  parameter int W = 27,
  parameter logic [W-1:0] MAXV = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic         ovf,
  output logic [W-1:0] result
);
  localparam int CW = $clog2(W);
  logic busy_q, busy_d, div_q, div_d, ovf_q, ovf_d, ge;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] acc_q, acc_d, x_q, x_d, y_q, y_d;
  logic [W+1:0] sum;
  logic [W:0] rem, diff;
  // one iteration per cycle: MSB-first accumulate (mul) or shift-and-subtract (div); done/result reflect the final step
  always_comb begin
    busy_d = busy_q;
    div_d = div_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    x_d = x_q;
    y_d = y_q;
    sum = {1'b0, acc_q, 1'b0} + (x_q[W-1] ? {2'b00, y_q} : {(W+2){1'b0}});
    rem = {acc_q, x_q[W-1]};
    diff = rem - {1'b0, y_q};
    ge = rem >= {1'b0, y_q};
    done = busy_q && cnt_q == CW'(W-1);
    if (start) begin
      busy_d = 1'b1;
      div_d = op_div;
      ovf_d = 1'b0;
      cnt_d = '0;
      acc_d = '0;
      x_d = op_div ? a : b;
      y_d = op_div ? b : a;
    end else if (busy_q) begin
      cnt_d = cnt_q + 1'b1;
      busy_d = !done;
      x_d = {x_q[W-2:0], div_q && ge};
      if (div_q) acc_d = ge ? diff[W-1:0] : rem[W-1:0];
      else if (sum > {2'b00, MAXV}) ovf_d = 1'b1;
      else acc_d = sum[W-1:0];
    end
    ovf = ovf_d;
    result = div_q ? x_d : acc_d;
  end
  // operand and iteration registers
  always_ff @(posedge clk)
    if (rst) begin
      busy_q <= 1'b0;
      div_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      x_q <= '0;
      y_q <= '0;
    end else begin
      busy_q <= busy_d;
      div_q <= div_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      x_q <= x_d;
      y_q <= y_d;
    end
endmodule

// File: rtl/calc_param.sv
// calc_param: decimal entry calculator with signed sub, overflow, mul/div and serial digit scan-out
module calc_param
  import calc_pkg::*;
#(
  parameter int NDIG = 8,
  parameter int W = 27,
  parameter bit ENABLE_DIV = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [3:0]              cmd,
  input  logic                    cmd_valid,
  output logic [1:0]              status,
  output logic [3:0]              data,
  output logic [$clog2(NDIG)-1:0] pos,
  output logic                    data_valid,
  output logic                    neg
);
  localparam int PW = $clog2(NDIG);
  localparam longint unsigned MAXL = max_val(NDIG);
  localparam logic [W-1:0] MAXV = W'(MAXL);
  localparam logic [W-1:0] TEN = W'(10);
  if ((65'd1 << W) <= 65'(MAXL)) begin : g_w_check
    $error("W too narrow to hold NDIG decimal digits");
  end
  calc_state_t state_q, state_d;
  logic [W-1:0] entry_q, entry_d, a_q, a_d, sc_q, sc_d, base, md_res;
  logic [3:0] op_q, op_d;
  logic [PW-1:0] pos_q, pos_d;
  logic neg_q, neg_d, res_q, res_d, scan_q, scan_d, pend_q, pend_d;
  logic go, accept, is_dig, is_op, bad_op, md_start, md_done, md_ovf;
  logic [W+3:0] app;
  logic [W:0] sum;
  calc_muldiv #(.W(W), .MAXV(MAXV)) u_md (
    .clk(clock), .rst(reset), .start(md_start), .op_div(op_q == CMD_DIV),
    .a(a_q), .b(entry_q), .done(md_done), .ovf(md_ovf), .result(md_res)
  );
  // command decode, state transitions, arithmetic and scan sequencing
  always_comb begin
    status = state_q == S_ERR ? ST_ERR
           : (scan_q || pend_q || state_q == S_MUL || state_q == S_DIV) ? ST_BUSY : ST_READY;
    data_valid = scan_q;
    pos = pos_q;
    data = scan_q ? 4'(sc_q % TEN) : 4'd0;
    neg = neg_q;
    accept = status == ST_READY && cmd_valid;
    is_dig = cmd <= 4'd9;
    bad_op = cmd == CMD_DIV && !ENABLE_DIV;
    is_op = cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_MUL || (cmd == CMD_DIV && ENABLE_DIV);
    base = res_q ? {W{1'b0}} : entry_q;
    app = {4'b0000, base} * (W+4)'(10) + (W+4)'(cmd);
    sum = {1'b0, a_q} + {1'b0, entry_q};
    state_d = state_q;
    entry_d = entry_q;
    a_d = a_q;
    op_d = op_q;
    neg_d = neg_q;
    res_d = res_q;
    md_start = 1'b0;
    go = pend_q;
    pend_d = 1'b0;
    if (accept) begin
      if (is_dig) begin
        if (app <= {4'b0000, MAXV}) begin
          entry_d = app[W-1:0];
          neg_d = neg_q && !res_q;
          res_d = 1'b0;
          go = 1'b1;
        end
      end else if (cmd == CMD_BKSP) begin
        entry_d = entry_q / TEN;
        go = 1'b1;
      end else if (is_op || bad_op) begin
        if (state_q == S_A && is_op && !neg_q) begin
          a_d = entry_q;
          op_d = cmd;
          entry_d = '0;
          res_d = 1'b0;
          go = 1'b1;
          state_d = S_B;
        end else state_d = S_ERR;
      end else if (state_q == S_B) begin
        if (op_q == CMD_MUL || op_q == CMD_DIV) begin
          md_start = !(op_q == CMD_DIV && entry_q == '0);
          state_d = op_q == CMD_MUL ? S_MUL : md_start ? S_DIV : S_ERR;
        end else if (op_q == CMD_ADD && sum > {1'b0, MAXV}) state_d = S_ERR;
        else begin
          entry_d = op_q == CMD_ADD ? sum[W-1:0] : a_q >= entry_q ? a_q - entry_q : entry_q - a_q;
          neg_d = op_q == CMD_SUB && a_q < entry_q;
          res_d = 1'b1;
          go = 1'b1;
          state_d = S_A;
        end
      end
    end
    if (md_done) begin
      state_d = md_ovf ? S_ERR : S_A;
      entry_d = md_res;
      neg_d = 1'b0;
      res_d = 1'b1;
      go = !md_ovf;
    end
    scan_d = scan_q;
    pos_d = pos_q;
    sc_d = sc_q;
    if (go) begin
      scan_d = 1'b1;
      pos_d = '0;
      sc_d = entry_d;
    end else if (scan_q) begin
      sc_d = sc_q / TEN;
      pos_d = pos_q + 1'b1;
      if (pos_q == PW'(NDIG-1)) begin
        scan_d = 1'b0;
        pos_d = '0;
      end
    end
  end
  // state and datapath registers; reset arms the initial scan of 0
  always_ff @(posedge clock)
    if (reset) begin
      state_q <= S_A;
      entry_q <= '0;
      a_q <= '0;
      op_q <= 4'h0;
      neg_q <= 1'b0;
      res_q <= 1'b0;
      scan_q <= 1'b0;
      pend_q <= 1'b1;
      pos_q <= '0;
      sc_q <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      a_q <= a_d;
      op_q <= op_d;
      neg_q <= neg_d;
      res_q <= res_d;
      scan_q <= scan_d;
      pend_q <= pend_d;
      pos_q <= pos_d;
      sc_q <= sc_d;
    end
endmodule
